data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Purpose: arbitrates CORES requesters onto one single-port data RAM (round-robin, or fixed priority with DMEM_ARB_FIXED_PRIO_EN).
// Latency: REQ sampled at posedge k -> WR/RD high k..k+1 -> one-hot ACK high k+1..k+2; one access per 3 cycles.
// Backpressure: a core holds REQ/WE/ADDR/WDATA until ACK; losers simply wait, a request dropped before grant is withdrawn.
module data_mem_arbiter #(
  parameter int CORES = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CORES-1:0]    REQ,
  input  logic [CORES-1:0]    WE,
  input  logic [CORES*AW-1:0] ADDR,
  input  logic [CORES*DW-1:0] WDATA,
  output logic [CORES-1:0]    ACK,
  output logic [DW-1:0]       RDATA,
  output logic [AW-1:0]       ADDBUS,
  output logic [DW-1:0]       DATAIN,
  output logic                WR,
  output logic                RD,
  input  logic [DW-1:0]       MEMOUT
);

  localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] grant;  // owner of the transaction in flight
  logic [PW-1:0] pick;   // combinational winner among current requests

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest requesting index is the last to overwrite pick
  always_comb begin
    pick = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (REQ[i]) pick = PW'(i);
    end
  end
`else
  logic [PW-1:0] ptr;    // first core to be considered at the next arbitration
  logic [PW:0]   cand;   // one extra bit so ptr+i cannot overflow before the wrap
  logic          found;

  // Round-robin: search upward from ptr with wrap, first requester wins
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < CORES; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(CORES)) cand = cand - (PW+1)'(CORES);
      if (!found && REQ[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  // Pointer advances to the core after the winner on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == IDLE && |REQ) begin
      ptr <= (pick == PW'(CORES - 1)) ? '0 : pick + 1'b1;
    end
  end
`endif

  // Three-state access sequencer; async reset drops WR so an in-flight write never commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      ACK    <= '0;
      RDATA  <= '0;
      ADDBUS <= '0;
      DATAIN <= '0;
      WR     <= 1'b0;
      RD     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|REQ) begin
            grant  <= pick;
            ADDBUS <= ADDR[pick*AW +: AW];
            DATAIN <= WDATA[pick*DW +: DW];
            WR     <= WE[pick];
            RD     <= ~WE[pick];
            state  <= ACCESS;
          end else begin
            WR <= 1'b0;
            RD <= 1'b0;
          end
        end
        ACCESS: begin
          // RAM commits the write on this edge; read data is captured on the same edge
          if (RD) RDATA <= MEMOUT;
          ACK        <= '0;
          ACK[grant] <= 1'b1;
          WR         <= 1'b0;
          RD         <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          ACK   <= '0;
          state <= IDLE;
        end
        default: begin
          ACK   <= '0;
          WR    <= 1'b0;
          RD    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data RAM.
// Expected values are hand-derived per transaction; builds with or without DMEM_ARB_FIXED_PRIO_EN.
// All checks go through chk; one summary line at the end.
module tb_data_mem_arbiter;

  localparam int CORES = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [CORES-1:0]    REQ;
  logic [CORES-1:0]    WE;
  logic [CORES*AW-1:0] ADDR;
  logic [CORES*DW-1:0] WDATA;
  logic [CORES-1:0]    ACK;
  logic [DW-1:0]       RDATA;
  logic [AW-1:0]       ADDBUS;
  logic [DW-1:0]       DATAIN;
  logic                WR;
  logic                RD;
  logic [DW-1:0]       MEMOUT;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] rdata_exp;
  logic [CORES-1:0] exp_ack;

  data_mem_arbiter #(.CORES(CORES), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .ADDBUS(ADDBUS), .DATAIN(DATAIN),
    .WR(WR), .RD(RD), .MEMOUT(MEMOUT)
  );

  always #5 clk = ~clk;

  // Behavioural data RAM: write commits on posedge with WR, read is combinational
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (WR) mem[ADDBUS] <= DATAIN;
  assign MEMOUT = mem[ADDBUS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One isolated access by a single core; checks strobes, latency, ACK and RDATA
  task automatic access(input int core, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    int n;
    @(negedge clk);
    REQ = '0;
    REQ[core] = 1'b1;
    WE = '0;
    WE[core] = we;
    ADDR[core*AW +: AW]  = addr;
    WDATA[core*DW +: DW] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(WR || RD) && n < 10);
    chk("grant_latency", n, 1);
    chk("wr", WR, we);
    chk("rd", RD, !we);
    chk("addbus", ADDBUS, addr);
    if (we) chk("datain", DATAIN, wd);
    chk("ack_early", ACK, 0);
    @(negedge clk);
    chk("ack", ACK, 32'(1) << core);
    chk("strobes_off", {WR, RD}, 0);
    if (!we) rdata_exp = exp_rd;
    chk("rdata", RDATA, rdata_exp);
    REQ = '0;
    @(negedge clk);
    chk("ack_clear", ACK, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; REQ = '0; WE = '0; ADDR = '0; WDATA = '0;
    rdata_exp = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ACK, 0);
    chk("rst_wrrd", {WR, RD}, 0);
    chk("rst_addbus", ADDBUS, 0);
    chk("rst_datain", DATAIN, 0);
    chk("rst_rdata", RDATA, 0);
    rst = 1'b0;

    // Core 1 writes 0x0010 <- 0xBEEF, core 2 reads it back
    access(1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    access(2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // Top-of-memory preload then core 3 read, ACK one cycle after strobe
    access(0, 1'b1, 16'hFFFF, 16'h1234, 16'h0000);
    access(3, 1'b0, 16'hFFFF, 16'h0000, 16'h1234);

    // Reset in the middle of a write's ACCESS cycle
    access(1, 1'b1, 16'h0020, 16'hA5A5, 16'h0000);
    @(negedge clk);
    REQ = 4'b0001; WE = 4'b0001;
    ADDR[0 +: AW] = 16'h0020; WDATA[0 +: DW] = 16'h5555;
    @(negedge clk);
    chk("mid_wr", WR, 1);
    rst = 1'b1;
    REQ = '0;
    #1;
    chk("midrst_wrrd", {WR, RD}, 0);
    chk("midrst_ack", ACK, 0);
    chk("midrst_addbus", ADDBUS, 0);
    chk("midrst_datain", DATAIN, 0);
    chk("midrst_rdata", RDATA, 0);
    @(negedge clk);
    chk("midrst_ack2", ACK, 0);
    rst = 1'b0;
    rdata_exp = '0;
    @(negedge clk);
    chk("midrst_mem", mem[16'h0020], 16'hA5A5);
    access(2, 1'b0, 16'h0020, 16'h0000, 16'hA5A5);

    // Fresh reset so the pointer is 0, then all four cores read continuously
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    REQ = '1; WE = '0; ADDR = '0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c >= 2 && (c - 2) % 3 == 0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_ack = 4'b0001;
`else
        exp_ack = 4'(1 << (((c - 2) / 3) % 4));
`endif
      end else begin
        exp_ack = '0;
      end
      chk($sformatf("rr_ack_c%0d", c), ACK, exp_ack);
      chk($sformatf("rr_excl_c%0d", c), WR && RD, 0);
    end
    REQ = '0;

    // Cores 0 and 3 compete; round-robin pointer now sits at 2
    @(negedge clk);
    REQ = 4'b1001; WE = '0;
    @(negedge clk);
    chk("rr2_rd", RD, 1);
    REQ = '0;
    @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    chk("rr2_ack", ACK, 4'b0001);
`else
    chk("rr2_ack", ACK, 4'b1000);
`endif
    @(negedge clk);

    // Core 0 drops REQ right after grant: still completes, no second grant
    @(negedge clk);
    REQ = 4'b0001; WE = '0; ADDR[0 +: AW] = 16'h0010;
    @(negedge clk);
    chk("drop_rd", RD, 1);
    REQ = '0;
    @(negedge clk);
    chk("drop_ack", ACK, 4'b0001);
    chk("drop_rdata", RDATA, 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("drop_quiet%0d", k), {ACK, WR, RD}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
